// File: rtl/hazard_stall_unit.sv
// Load-use, branch-squash and data-memory-wait stall/flush control for the 5-stage core.
// Control outputs are combinational from the current state and inputs (zero latency); state, timeout flag and stall counter are registered.
module hazard_stall_unit #(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP} state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       load_use;
    logic       mem_stall;
    logic       frozen;

    always_comb begin
        load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));
        mem_stall = mem_req && !mem_ready;
        // Once waiting, the access is held in MEM and only mem_ready releases it.
        frozen    = ((state == RUN) && mem_stall) ||
                    ((state == MEM_WAIT) && !mem_ready);
    end

    always_comb begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        exmem_hold = 1'b0;
        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (state == TRAP) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exmem_hold = 1'b1;
        end else if (frozen) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            exmem_hold = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            wait_cnt     <= 8'd0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= 8'd1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= 8'd0;
                    end else if (wait_cnt == MAX_WAIT_C) begin
                        state       <= TRAP;
                        mem_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                TRAP: state <= TRAP;
                default: state <= RUN;
            endcase

            if ((state != TRAP) && !pc_write && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: per-cycle comparison against a spec-level model plus directed literal checks.
module tb_hazard_stall_unit;

    localparam int MW = 4;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mem_req, mem_ready;
    logic          pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, mem_timeout;
    logic [CW-1:0] stall_cycles;

    int checks = 0;
    int failures = 0;

    hazard_stall_unit #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_hold(exmem_hold), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: consecutive frozen-cycle count, trap flag, timeout flag, saturating stall count.
    int m_consec = 0, n_consec = 0;
    bit m_trap = 0, n_trap = 0;
    bit m_tmo = 0, n_tmo = 0;
    int m_stalls = 0, n_stalls = 0;

    always @(negedge clk) begin
        logic       lu, frz;
        logic [4:0] e;
        lu  = ex_mem_read && (ex_rd != 0) &&
              ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        frz = 1'b0;
        if (reset)       e = 5'b00110;
        else if (m_trap) e = 5'b00111;
        else begin
            frz = (m_consec > 0) ? !mem_ready : (mem_req && !mem_ready);
            if (frz)                  e = 5'b00001;
            else if (ex_branch_taken) e = 5'b11110;
            else if (lu)              e = 5'b00010;
            else                      e = 5'b11000;
        end
        chk("cyc_ctrl", {27'd0, pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold}, {27'd0, e});
        chk("cyc_timeout", {31'd0, mem_timeout}, {31'd0, m_tmo});
        chk("cyc_stalls", {28'd0, stall_cycles}, m_stalls);

        n_consec = m_consec; n_trap = m_trap; n_tmo = m_tmo; n_stalls = m_stalls;
        if (reset) begin
            n_consec = 0; n_trap = 0; n_tmo = 0; n_stalls = 0;
        end else if (!m_trap) begin
            if (e[4] == 1'b0 && m_stalls < SAT) n_stalls = m_stalls + 1;
            if (frz) begin
                n_consec = m_consec + 1;
                if (n_consec > MW) begin n_trap = 1; n_tmo = 1; end
            end else begin
                n_consec = 0;
            end
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_consec <= 0; m_trap <= 0; m_tmo <= 0; m_stalls <= 0;
        end else begin
            m_consec <= n_consec; m_trap <= n_trap; m_tmo <= n_tmo; m_stalls <= n_stalls;
        end
    end

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1, input logic u2,
                          input logic mrd, input logic [4:0] rd, input logic br,
                          input logic mq, input logic mr);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_mem_read = mrd; ex_rd = rd; ex_branch_taken = br; mem_req = mq; mem_ready = mr;
    endtask

    task automatic idle();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        next_cyc();
        reset = 1'b1;
        idle();
        next_cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #2;
        chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
        chk("rst_flushes", {30'd0, ifid_flush, idex_flush}, 32'd3);
        chk("rst_hold", {31'd0, exmem_hold}, 32'd0);
        chk("rst_stalls", {28'd0, stall_cycles}, 32'd0);
        next_cyc();
        reset = 1'b0;

        // Load x5 in EX, ID reads rs2 = x5.
        set_in(5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lu_ctrl", {27'd0, pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold}, 32'b00010);
        next_cyc();
        idle();
        #1;
        chk("lu_stalls", {28'd0, stall_cycles}, 32'd1);
        chk("lu_after_pc", {31'd0, pc_write}, 32'd1);
        set_in(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lu_rd0", {31'd0, pc_write}, 32'd1);
        next_cyc();
        set_in(5'd3, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lu_nouse", {31'd0, pc_write}, 32'd1);
        next_cyc();

        // Branch together with load-use: branch wins, no stall.
        set_in(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        #1;
        chk("br_lu_ctrl", {27'd0, pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold}, 32'b11110);
        next_cyc();
        idle();
        #1;
        chk("br_lu_stalls", {28'd0, stall_cycles}, 32'd1);

        // Three not-ready cycles, branch ignored while frozen, acted on at release.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, i == 1, 1'b1, 1'b0);
            #1;
            chk("mw_frozen", {27'd0, pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold}, 32'b00001);
            next_cyc();
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        #1;
        chk("mw_release", {27'd0, pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold}, 32'b11110);
        next_cyc();
        idle();
        #1;
        chk("mw_stalls", {28'd0, stall_cycles}, 32'd3);
        chk("mw_back_run", {31'd0, pc_write}, 32'd1);

        // Timeout: MW+1 frozen cycles then TRAP.
        do_reset();
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (MW + 1) next_cyc();
        chk("to_ctrl", {27'd0, pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold}, 32'b00111);
        chk("to_flag", {31'd0, mem_timeout}, 32'd1);
        chk("to_stalls", {28'd0, stall_cycles}, 32'd5);
        next_cyc();
        chk("to_stalls_hold", {28'd0, stall_cycles}, 32'd5);
        #2;
        reset = 1'b1;
        #1;
        chk("to_rst_flag", {31'd0, mem_timeout}, 32'd0);
        chk("to_rst_hold", {31'd0, exmem_hold}, 32'd0);
        next_cyc();
        reset = 1'b0;

        // Asynchronous reset between edges while in MEM_WAIT.
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        next_cyc();
        next_cyc();
        #2;
        reset = 1'b1;
        #1;
        chk("arst_ctrl", {27'd0, pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold}, 32'b00110);
        chk("arst_stalls", {28'd0, stall_cycles}, 32'd0);
        next_cyc();
        idle();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_run", {31'd0, pc_write}, 32'd1);
        next_cyc();
        chk("arst_stalls_after", {28'd0, stall_cycles}, 32'd0);

        // Continuous load-use stalls saturate the counter.
        set_in(5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
        repeat (20) next_cyc();
        chk("sat_stalls", {28'd0, stall_cycles}, 32'd15);
        chk("sat_pc", {31'd0, pc_write}, 32'd0);
        idle();
        next_cyc();
        next_cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
